// File: rtl/pattern_gen.sv
// Test pattern generator for a VGA pipeline.
// Renders vertical bars, horizontal bars, a checkerboard or scrolling bars.
// The pattern mode and scroll offset change only at frame boundaries.
module pattern_gen #(
    parameter int unsigned H_ACTIVE    = 640,
    parameter int unsigned V_ACTIVE    = 480,
    parameter int unsigned NUM_BARS    = 6,
    parameter int unsigned CELL_LOG2   = 5,
    parameter int unsigned SCROLL_STEP = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clken,
    input  logic [1:0]  mode_req,
    input  logic        freeze,
    input  logic [9:0]  h_addr,
    input  logic [9:0]  v_addr,
    input  logic        valid,
    input  logic        v_sync,
    output logic [23:0] data,
    output logic [1:0]  mode_cur,
    output logic [15:0] frame_cnt
);

    // 11-bit arithmetic so h_addr + offset never overflows for H_ACTIVE <= 1023
    localparam logic [10:0] HACT    = 11'(H_ACTIVE);
    localparam logic [10:0] BAR_W   = 11'(H_ACTIVE / NUM_BARS);
    localparam logic [10:0] BAR_H   = 11'(V_ACTIVE / NUM_BARS);
    localparam logic [10:0] MAX_BAR = 11'(NUM_BARS - 1);
    localparam logic [10:0] STEP    = 11'(SCROLL_STEP);

    logic [23:0] data_q, data_d;
    logic [1:0]  mode_q, mode_d;
    logic [15:0] frame_q, frame_d;
    logic [9:0]  offset_q, offset_d;
    logic        vs_prev_q;

    logic        frame_edge;
    logic [10:0] scroll_sum;
    logic [10:0] scroll_x;
    logic [10:0] off_sum;

    function automatic logic [23:0] palette(input logic [2:0] idx);
        logic [23:0] c;
        case (idx)
            3'd0:    c = 24'hFF0000;
            3'd1:    c = 24'h00FF00;
            3'd2:    c = 24'h0000FF;
            3'd3:    c = 24'hFFFF00;
            3'd4:    c = 24'h00FFFF;
            3'd5:    c = 24'hFF00FF;
            3'd6:    c = 24'hFFFFFF;
            default: c = 24'h808080;
        endcase
        return c;
    endfunction

    // Bar colour for a position; the last bar absorbs the division remainder.
    function automatic logic [23:0] bar_colour(input logic [10:0] pos, input logic [10:0] width);
        logic [10:0] q;
        logic [2:0]  idx;
        q   = pos / width;
        idx = (q > MAX_BAR) ? MAX_BAR[2:0] : q[2:0];
        return palette(idx);
    endfunction

    // Frame boundary detection, next offset and pixel colour
    always_comb begin
        frame_edge = vs_prev_q & ~v_sync;

        scroll_sum = {1'b0, h_addr} + {1'b0, offset_q};
        scroll_x   = (scroll_sum >= HACT) ? scroll_sum - HACT : scroll_sum;

        off_sum    = {1'b0, offset_q} + STEP;

        mode_d   = mode_q;
        frame_d  = frame_q;
        offset_d = offset_q;
        if (frame_edge) begin
            mode_d  = mode_req;
            frame_d = frame_q + 16'd1;
            if (!freeze) begin
                offset_d = 10'((off_sum >= HACT) ? off_sum - HACT : off_sum);
            end
        end

        data_d = 24'h000000;
        if (valid) begin
            unique case (mode_q)
                2'd0: data_d = bar_colour({1'b0, h_addr}, BAR_W);
                2'd1: data_d = bar_colour({1'b0, v_addr}, BAR_H);
                2'd2: data_d = (h_addr[CELL_LOG2] ^ v_addr[CELL_LOG2]) ? 24'hFFFFFF : 24'h000000;
                2'd3: data_d = bar_colour(scroll_x, BAR_W);
                default: data_d = 24'h000000;
            endcase
        end
    end

    // State register; reset wins over clken and any coincident frame boundary
    always_ff @(posedge clk) begin
        if (!reset) begin
            data_q    <= 24'h000000;
            mode_q    <= 2'd0;
            frame_q   <= 16'd0;
            offset_q  <= 10'd0;
            vs_prev_q <= 1'b1;
        end else if (clken) begin
            data_q    <= data_d;
            mode_q    <= mode_d;
            frame_q   <= frame_d;
            offset_q  <= offset_d;
            vs_prev_q <= v_sync;
        end
    end

    assign data      = data_q;
    assign mode_cur  = mode_q;
    assign frame_cnt = frame_q;

endmodule

// File: doc/pattern_gen.md
PATTERN_GEN -- requirements
Module: pattern_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL have parameter V_ACTIVE, default 480, visible lines per frame.
REQ-003 SHALL have parameter NUM_BARS, default 6, bar count for bar modes (range 1..8).
REQ-004 SHALL have parameter CELL_LOG2, default 5, log2 of checker cell edge in pixels.
REQ-005 SHALL have parameter SCROLL_STEP, default 4, pixels of scroll advance per frame.
REQ-006 SHALL have port clk, input, 1, single clock for all logic (pixel clock domain).
REQ-007 SHALL have port reset, input, 1, synchronous, active-low reset.
REQ-008 SHALL have port clken, input, 1, pixel enable; all state advances only when 1.
REQ-009 SHALL have port mode_req, input, 2, requested pattern mode.
REQ-010 SHALL have port freeze, input, 1, holds the scroll offset when 1.
REQ-011 SHALL have port h_addr, input, 10, current pixel column.
REQ-012 SHALL have port v_addr, input, 10, current pixel row.
REQ-013 SHALL have port valid, input, 1, current pixel is in the active area.
REQ-014 SHALL have port v_sync, input, 1, active-low vertical sync from the VGA controller.
REQ-015 SHALL have port data, output, 24, registered pixel colour {R[7:0],G[7:0],B[7:0]}.
REQ-016 SHALL have port mode_cur, output, 2, mode currently being rendered.
REQ-017 SHALL have port frame_cnt, output, 16, count of completed frames.

Function
REQ-018 SHALL derive BAR_W = H_ACTIVE/NUM_BARS and BAR_H = V_ACTIVE/NUM_BARS (integer division); computed bar index SHALL clamp to NUM_BARS-1.
REQ-019 SHALL use palette index 0..7 = FF0000, 00FF00, 0000FF, FFFF00, 00FFFF, FF00FF, FFFFFF, 808080.
REQ-020 SHALL detect the frame boundary as a 1->0 transition of v_sync, sampled on clk cycles with clken=1 (one registered previous v_sync sample).
REQ-021 SHALL, on each frame boundary: increment frame_cnt (wrap FFFF->0000), load mode_cur <= mode_req, and, if freeze=0, advance offset by SCROLL_STEP modulo H_ACTIVE.
REQ-022 SHALL ignore mode_req changes between frame boundaries; no mid-frame mode switch.
REQ-023 Mode 0 (vertical bars): data = palette[clamp(h_addr/BAR_W)].
REQ-024 Mode 1 (horizontal bars): data = palette[clamp(v_addr/BAR_H)].
REQ-025 Mode 2 (checker): data = FFFFFF when h_addr[CELL_LOG2]^v_addr[CELL_LOG2]=1, else 000000.
REQ-026 Mode 3 (scroll bars): x = (h_addr+offset), minus H_ACTIVE if >= H_ACTIVE; data = palette[clamp(x/BAR_W)].
REQ-027 SHALL output data = 000000 for any pixel with valid=0.
REQ-028 SHALL register data with latency exactly 1 clken-qualified cycle from h_addr/v_addr/valid.
REQ-029 SHALL hold data, offset, frame_cnt, mode_cur and the v_sync history when clken=0.
REQ-030 SHALL perform the offset wrap with an 11-bit sum, so no overflow occurs for H_ACTIVE up to 1023.

Reset
REQ-031 SHALL, when reset=0 at a clk edge (regardless of clken), set data=000000, mode_cur=0, frame_cnt=0, offset=0, and v_sync history=1.
REQ-032 SHALL let reset override a simultaneous frame boundary; no increment or mode load on that cycle.
REQ-033 SHALL resume from mode 0 after a mid-frame reset until the next frame boundary.

Verification
REQ-034 Mode 0, defaults, valid=1: h_addr=105 -> 0xFF0000; 106 -> 0x00FF00; 636 -> 0xFF00FF (clamped bar 5); all one cycle later.
REQ-035 Mode 1, defaults: v_addr=79 -> 0xFF0000; v_addr=80 -> 0x00FF00; valid=0 with any address -> 0x000000.
REQ-036 Mode 2: (h,v)=(31,0) -> 0x000000; (32,0) -> 0xFFFFFF; (32,32) -> 0x000000.
REQ-037 mode_req=3 mid-frame: mode_cur stays 0 until the v_sync fall; after 2 boundaries, offset=8, h_addr=100 -> x=108 -> 0x00FF00; frame_cnt=2.
REQ-038 Force offset=636, one boundary with freeze=0 -> offset=0; with freeze=1 -> offset stays 636 while frame_cnt still increments.
REQ-039 clken=0 for 10 cycles including a v_sync fall -> no output/state change; reset=0 coincident with a v_sync fall -> all outputs 0.
